// File: rtl/mux_scan_pkg.sv
// Shared encodings and helpers for the mux_scan block.
package mux_scan_pkg;

    // Encodings of the external mode input.
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Selection FSM states; the state tracks the mode input one cycle late.
    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_next.sv
// Next-enabled-channel finder: returns the first enabled channel above
// i_cur_sel, wrapping to the lowest enabled channel when none lies above.
module mux_scan_next
    import mux_scan_pkg::*;
#(
    parameter  int NCH  = 8,
    localparam int SELW = clog2(NCH)
) (
    input  logic [SELW-1:0] i_cur_sel,
    input  logic [NCH-1:0]  i_mask,
    output logic [SELW-1:0] o_next_sel,
    output logic            o_wrap,
    output logic            o_any
);

    logic            w_above_found;
    logic [SELW-1:0] w_above;
    logic            w_low_found;
    logic [SELW-1:0] w_low;

    // Scan downward so the lowest qualifying channel is the last one written.
    // NOTE: every variable gets a default before the loop; a path that left
    // one unassigned would make synthesis infer a latch.
    always_comb begin
        w_above_found = 1'b0;
        w_above       = '0;
        w_low_found   = 1'b0;
        w_low         = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (i_mask[j]) begin
                w_low_found = 1'b1;
                w_low       = SELW'(j);
                if (j > int'(i_cur_sel)) begin
                    w_above_found = 1'b1;
                    w_above       = SELW'(j);
                end
            end
        end
    end

    // Wrapping to the lowest enabled channel means new index <= old index,
    // which also covers a single enabled channel selecting itself.
    assign o_next_sel = w_above_found ? w_above : (w_low_found ? w_low : i_cur_sel);
    assign o_wrap     = !w_above_found && w_low_found;
    assign o_any      = w_low_found;

endmodule

// File: rtl/mux_scan.sv
// mux_scan: N-channel registered multiplexer with manual selection and a
// dwell-timed auto-scan sequencer, valid/ready output handshake.
// Optional feature macro: MUX_SCAN_MASK_EN adds the ch_mask port so that
// disabled channels are skipped by the scan and refused by sel_ld.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter  int NCH   = 8,
    parameter  int W     = 8,
    parameter  int DWELL = 4,
    localparam int SELW  = clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*W-1:0]  d,
    input  logic              mode,
    input  logic [SELW-1:0]   sel_in,
    input  logic              sel_ld,
    input  logic              hold,
    input  logic              out_ready,
`ifdef MUX_SCAN_MASK_EN
    input  logic [NCH-1:0]    ch_mask,
`endif
    output logic [W-1:0]      y,
    output logic [SELW-1:0]   y_ch,
    output logic              y_valid,
    output logic              scan_wrap
);

    localparam int              DWW        = cnt_width(DWELL);
    localparam logic [DWW-1:0]  DWELL_LAST = DWW'(DWELL - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SELW-1:0] r_cur_sel;
    logic [SELW-1:0] w_cur_nxt;
    logic [DWW-1:0]  r_dwell;
    logic [DWW-1:0]  w_dwell_nxt;
    logic            w_wrap_nxt;
    logic [W-1:0]    r_y;
    logic [SELW-1:0] r_y_ch;
    logic            r_y_valid;
    logic            r_scan_wrap;

    logic [W-1:0]    w_ch [NCH];
    logic [NCH-1:0]  w_mask;
    logic            w_cur_en;
    logic            w_sel_en;
    logic [SELW-1:0] w_next_sel;
    logic            w_next_wrap;
    logic            w_any;
    logic            w_stall;
    logic            w_snap;
    logic            w_step_en;
    logic [SELW-1:0] w_cap_sel;

    // Unflatten the channel bus.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_ch[i] = d[i*W +: W];
    end

`ifdef MUX_SCAN_MASK_EN
    assign w_mask   = ch_mask;
    assign w_cur_en = ch_mask[r_cur_sel];
    assign w_sel_en = (int'(sel_in) < NCH) && ch_mask[sel_in];
`else
    assign w_mask   = '1;
    assign w_cur_en = 1'b1;
    assign w_sel_en = (int'(sel_in) < NCH);
`endif

    mux_scan_next #(
        .NCH (NCH)
    ) u_next (
        .i_cur_sel  (r_cur_sel),
        .i_mask     (w_mask),
        .o_next_sel (w_next_sel),
        .o_wrap     (w_next_wrap),
        .o_any      (w_any)
    );

    // A held output that downstream has not taken freezes capture and scan.
    assign w_stall   = r_y_valid && !out_ready;
    assign w_step_en = !hold && !w_stall && w_any;
    // Leaving the invalid state onto a masked channel first snaps to an enabled one.
    assign w_snap    = w_any && !r_y_valid && !w_cur_en;
    assign w_cap_sel = w_snap ? w_next_sel : r_cur_sel;

    // Next-state logic: FSM follows mode, select/dwell sequencing with sel_ld priority.
    always_comb begin
        w_state_nxt = (mode == MODE_MANUAL) ? ST_MANUAL : ST_SCAN;
        w_cur_nxt   = r_cur_sel;
        w_dwell_nxt = r_dwell;
        w_wrap_nxt  = 1'b0;
        if (sel_ld && w_sel_en) begin
            w_cur_nxt   = sel_in;
            w_dwell_nxt = '0;
        end else if (w_snap) begin
            w_cur_nxt   = w_next_sel;
            w_dwell_nxt = '0;
        end else if (r_state == ST_SCAN) begin
            if (w_step_en) begin
                if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    w_cur_nxt   = w_next_sel;
                    w_wrap_nxt  = w_next_wrap;
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
        end else begin
            w_dwell_nxt = '0;
        end
    end

    // State register for the FSM and the select sequencer.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_MANUAL;
            r_cur_sel   <= '0;
            r_dwell     <= '0;
            r_scan_wrap <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_sel   <= w_cur_nxt;
            r_dwell     <= w_dwell_nxt;
            r_scan_wrap <= w_wrap_nxt;
        end
    end

    // Output capture register with valid/ready hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y       <= '0;
            r_y_ch    <= '0;
            r_y_valid <= 1'b0;
        end else if (!w_any) begin
            r_y_valid <= 1'b0;
        end else if (!w_stall) begin
            r_y       <= w_ch[w_cap_sel];
            r_y_ch    <= w_cap_sel;
            r_y_valid <= 1'b1;
        end
    end

    assign y         = r_y;
    assign y_ch      = r_y_ch;
    assign y_valid   = r_y_valid;
    assign scan_wrap = r_scan_wrap;

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised N-channel, W-bit registered multiplexer with manual and auto-scan selection. It is the sequential successor of the team's fixed 8:1 gate-level mux. A select register is driven either by a load strobe or by a dwell-timed channel sequencer. Output is registered with a valid/ready handshake, so it can feed display, UART or logic-analyser sampling paths in the lab designs.

## Interface
- NCH, 8, number of input channels (2..64, need not be a power of 2)
- W, 8, channel data width
- DWELL, 4, cycles spent on each channel in scan mode (≥1)
- SELW, $clog2(NCH), select width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- d  in  NCH*W  flattened channel data; channel i at d[i*W +: W]
- mode  in  1  0 = manual, 1 = auto-scan
- sel_in  in  SELW  channel index to load
- sel_ld  in  1  load strobe for sel_in
- hold  in  1  freezes the scan sequencer
- out_ready  in  1  downstream ready
- ch_mask  in  NCH  channel enable mask (only with MUX_SCAN_MASK_EN)
- y  out  W  registered selected data
- y_ch  out  SELW  channel index that y was captured from
- y_valid  out  1  y/y_ch valid
- scan_wrap  out  1  one-cycle pulse when the scan wraps to the lowest channel

## Operation
- Internal state: cur_sel (SELW), dwell_cnt (0..DWELL-1), FSM {MANUAL, SCAN}. The FSM state follows `mode` registered, with one cycle of delay.
- Capture: on each edge where not (y_valid && !out_ready), y <= d[cur_sel], y_ch <= cur_sel, y_valid <= 1. A stalled cycle holds y, y_ch and y_valid.
- sel_ld: loads cur_sel <= sel_in and clears dwell_cnt in either mode. If sel_in ≥ NCH, the load is ignored entirely.
- SCAN: dwell_cnt increments on each non-stalled cycle with hold=0. At DWELL-1 it returns to 0 and cur_sel advances to (cur_sel+1) mod NCH. The advance from NCH-1 to 0 sets scan_wrap=1 for the next cycle only.
- MANUAL: cur_sel changes only via sel_ld. dwell_cnt is held at 0 and scan_wrap stays 0.
- Mode changes:
  - SCAN→MANUAL keeps cur_sel.
  - MANUAL→SCAN starts at dwell_cnt=0 from the current cur_sel.
- Simultaneous events:
  - sel_ld wins over dwell expiry, and no scan_wrap is generated.
  - hold and stall both freeze dwell_cnt and cur_sel. sel_ld still acts.

## Timing
- Reset (async) clears immediately: y=0, y_ch=0, y_valid=0, scan_wrap=0, cur_sel=0, dwell_cnt=0, FSM=MANUAL.
- First capture occurs on the first edge after rst deasserts.
- Latency:
  - d→y is 1 cycle.
  - sel_ld at edge t updates cur_sel at t; new channel data appears on y after edge t+1.
  - In scan mode, each channel appears on y_ch for DWELL consecutive captures.
- Handshake: a transfer occurs when y_valid && out_ready. y/y_ch are stable while y_valid && !out_ready. After reset, y_valid stays 1 except in the mask-all-zero case.
- Reset asserted mid-scan aborts the dwell; the scan restarts at channel 0 in MANUAL mode.

## Configuration
- MUX_SCAN_MASK_EN defined:
  - The ch_mask port exists.
  - Scan advance moves to the next enabled channel above cur_sel, modulo NCH. scan_wrap pulses when the new index ≤ the old index, including when a single channel is enabled.
  - sel_ld to a masked channel is ignored.
  - If ch_mask=0: no capture, y_valid<=0, y held, sequencer frozen. Capture and y_valid resume once any bit is set; if cur_sel is masked, it first advances to the next enabled channel.
  - A cur_sel that becomes masked while enabled channels remain is left on the next dwell expiry (scan) or by the next valid sel_ld (manual).
- Undefined: no ch_mask port; all channels are treated as enabled.

## Structure
- Package mux_scan_pkg holds:
  - mode encodings (MODE_MANUAL=0, MODE_SCAN=1)
  - FSM state encodings
  - the clog2 helper function
- One combinational sub-module, mux_scan_next, computes the next enabled index and a wrap flag from cur_sel and the mask. With the macro off, it is fed all-ones.

## Test plan
NCH=8, W=8, DWELL=4, d channel i = 8'h10+i, out_ready=1 unless stated.
- Reset: hold rst=1, then release → all outputs 0 during reset; after 1st edge y=8'h10, y_ch=0, y_valid=1.
- Manual:
  - sel_in=5, sel_ld pulse → y=8'h15, y_ch=5 after the following edge.
  - sel_in=3'd7 then sel_in beyond range (NCH=6 build, sel_in=6) → y_ch stays 7 / unchanged respectively.
- Scan: mode=1 for 40 cycles → y_ch sequence 0,1,…,7,0 with 4 cycles each; exactly one scan_wrap pulse at the 7→0 step.
- Backpressure: out_ready=0 for 6 cycles after 2 dwell cycles on ch3 → y=8'h13 frozen; after release, ch3 shown 2 more cycles, then ch4.
- Priority: sel_ld sel_in=1 on a dwell-expiry cycle at ch7 → y_ch goes to 1, no scan_wrap. Raising hold for 10 cycles → y_ch stays constant.
- Mask (macro on):
  - ch_mask=8'b1010_0101 → scan order 0,2,5,7,0, wrap pulse on 7→0.
  - ch_mask=0 → y_valid=0 next edge.
  - Restoring 8'h01 → y_valid=1, y_ch=0.
